// File: rtl/csr_pkg.sv
// ---------------------------------------------------------------------------
// csr_pkg
// Shared CSR register layouts and SoC constants for the ADC capture path.
//   adc_tx_t        : ADCx_TX write/readback layout ({busy, test, rsvd, time_us})
//   adc_rx_t        : ADCx_RX readback layout ({rsvd, sample_cnt})
//   ADC_SAMPLE_MAX  : most samples one measurement window may store
//   ADCx_SDRAM_BASE : per-channel SDRAM byte address of sample 0
//   adc_state_t     : sequencer states
// ---------------------------------------------------------------------------
package csr_pkg;

  typedef struct packed {
    logic        busy;
    logic        test;
    logic [14:0] rsvd;
    logic [14:0] time_us;
  } adc_tx_t;

  typedef struct packed {
    logic [14:0] rsvd;
    logic [16:0] sample_cnt;
  } adc_rx_t;

  localparam logic [16:0] ADC_SAMPLE_MAX = 17'h1_2000;

  // Each channel owns 2*ADC_SAMPLE_MAX bytes of SDRAM; the regions are back to back.
  localparam logic [23:0] ADC1_SDRAM_BASE = 24'h00_0000;
  localparam logic [23:0] ADC2_SDRAM_BASE = ADC1_SDRAM_BASE + 24'({ADC_SAMPLE_MAX, 1'b0});

  typedef enum logic [1:0] {
    ADC_IDLE  = 2'd0,
    ADC_RUN   = 2'd1,
    ADC_DRAIN = 2'd2
  } adc_state_t;

endpackage

// File: rtl/adc_capture_ctrl_fifo.sv
// ---------------------------------------------------------------------------
// adc_sample_fifo
// Small synchronous FIFO buffering 16-bit ADC samples ahead of the DMA writer.
//   clk, rst : clock, synchronous active-high reset (flushes contents)
//   push     : write wdata (accepted when not full, or when full and popping)
//   pop      : remove head entry (ignored when empty)
//   wdata    : sample to store
//   rdata    : current head entry
//   full     : DEPTH entries stored
//   empty    : nothing stored
// ---------------------------------------------------------------------------
module adc_sample_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        full,
  output logic        empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          wr_en;
  logic          rd_en;

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// ---------------------------------------------------------------------------
// adc_capture_ctrl
// Per-channel ADC measurement sequencer. A CSR write starts a window of
// time_us microseconds; samples come from the ADC deserializer or from an
// incrementing test pattern and are DMA'd to SDRAM through a small FIFO.
//   clk, rst      : clock, synchronous active-high reset
//   csr_we        : write strobe for ADCx_TX (adc_tx_t in csr_wdata)
//   csr_tx_rdata  : {busy, 31'b0}
//   csr_rx_rdata  : {15'b0, sample_cnt}
//   adc_en        : front-end enable (real-mode RUN only)
//   adc_vld/data  : deserializer sample strobe and value
//   dma_vld/rdy   : SDRAM write handshake, transfer on vld & rdy
//   dma_addr/data : SDRAM byte address and sample of the FIFO head
//   oflow         : one-cycle pulse per dropped sample
// ---------------------------------------------------------------------------
module adc_capture_ctrl
  import csr_pkg::*;
#(
  parameter int          CLK_MHZ    = 50,
  parameter logic [23:0] SDRAM_BASE = 24'h00_0000,
  parameter int          TEST_DIV   = 24,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_we,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_tx_rdata,
  output logic [31:0] csr_rx_rdata,
  output logic        adc_en,
  input  logic        adc_vld,
  input  logic [15:0] adc_data,
  output logic        dma_vld,
  input  logic        dma_rdy,
  output logic [23:0] dma_addr,
  output logic [15:0] dma_data,
  output logic        oflow
);

  localparam int PRE_W = $clog2(CLK_MHZ + 1);
  localparam int DIV_W = $clog2(TEST_DIV + 1);

  adc_state_t  state;
  adc_state_t  state_nxt;
  adc_tx_t     wr;
  adc_rx_t     rx;

  logic             test_mode;
  logic [14:0]      us_cnt;
  logic [PRE_W-1:0] pre_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [15:0]      pattern;
  logic [16:0]      pushed_cnt;
  logic [16:0]      sample_cnt;

  logic        busy;
  logic        in_run;
  logic        start;
  logic        clear_only;
  logic        us_tick;
  logic        window_end;
  logic        test_tick;
  logic        sample_vld;
  logic [15:0] sample_val;
  logic        can_push;
  logic        push;
  logic        drop;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic        unused_wdata;

  assign wr           = adc_tx_t'(csr_wdata);
  assign unused_wdata = &{1'b0, wr.busy, wr.rsvd};

  assign busy       = (state != ADC_IDLE);
  assign in_run     = (state == ADC_RUN);
  assign start      = csr_we & (state == ADC_IDLE) & (wr.time_us != '0);
  assign clear_only = csr_we & (state == ADC_IDLE) & (wr.time_us == '0);

  // The window closes on the last prescaler wrap of the last microsecond,
  // so RUN spans exactly time_us*CLK_MHZ cycles.
  assign us_tick    = in_run & (pre_cnt == '0);
  assign window_end = us_tick & (us_cnt == 15'd1);

  assign test_tick  = in_run & test_mode & (div_cnt == '0);
  assign sample_vld = in_run & (test_mode ? test_tick : adc_vld);
  assign sample_val = test_mode ? pattern : adc_data;

  // A sample is kept when there is room (a pop frees a slot this cycle) and
  // the window has not yet stored its quota.
  assign pop      = dma_vld & dma_rdy;
  assign can_push = (~fifo_full | pop) & (pushed_cnt != ADC_SAMPLE_MAX);
  assign push     = sample_vld & can_push;
  assign drop     = sample_vld & ~can_push;

  assign adc_en   = in_run & ~test_mode;
  assign dma_vld  = ~fifo_empty;
  assign dma_addr = SDRAM_BASE + {6'b0, sample_cnt, 1'b0};

  assign rx.rsvd       = '0;
  assign rx.sample_cnt = sample_cnt;
  assign csr_tx_rdata  = {busy, 31'b0};
  assign csr_rx_rdata  = rx;

  adc_sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (sample_val),
    .rdata (dma_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register for the IDLE/RUN/DRAIN sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ADC_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: start on a non-zero window, stop producing at the end
  // of the window, and go idle once everything has left for SDRAM.
  always_comb begin
    state_nxt = state;
    case (state)
      ADC_IDLE:  if (start)      state_nxt = ADC_RUN;
      ADC_RUN:   if (window_end) state_nxt = ADC_DRAIN;
      ADC_DRAIN: if (fifo_empty) state_nxt = ADC_IDLE;
      default:   state_nxt = ADC_IDLE;
    endcase
  end

  // Window timing, test-pattern generation and the sample/transfer counters.
  // A start write re-arms everything; writes while busy never reach here
  // because start and clear_only both require IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      test_mode  <= 1'b0;
      us_cnt     <= '0;
      pre_cnt    <= '0;
      div_cnt    <= '0;
      pattern    <= '0;
      pushed_cnt <= '0;
      sample_cnt <= '0;
      oflow      <= 1'b0;
    end else begin
      oflow <= drop;
      if (start) begin
        test_mode  <= wr.test;
        us_cnt     <= wr.time_us;
        pre_cnt    <= PRE_W'(CLK_MHZ - 1);
        div_cnt    <= DIV_W'(TEST_DIV - 1);
        pattern    <= '0;
        pushed_cnt <= '0;
        sample_cnt <= '0;
      end else begin
        if (clear_only) begin
          sample_cnt <= '0;
        end else if (pop) begin
          sample_cnt <= sample_cnt + 1'b1;
        end
        if (in_run) begin
          if (us_tick) begin
            pre_cnt <= PRE_W'(CLK_MHZ - 1);
            us_cnt  <= us_cnt - 1'b1;
          end else begin
            pre_cnt <= pre_cnt - 1'b1;
          end
          if (test_mode) begin
            if (test_tick) begin
              div_cnt <= DIV_W'(TEST_DIV - 1);
              pattern <= pattern + 1'b1;
            end else begin
              div_cnt <= div_cnt - 1'b1;
            end
          end
        end
        if (push) begin
          pushed_cnt <= pushed_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adc_capture_ctrl
// Directed bench for adc_capture_ctrl: test-pattern window, ignored busy
// write, zero-length write, back-pressure overflow, reset mid-run and
// sample-count saturation.
// ---------------------------------------------------------------------------
module tb_adc_capture_ctrl;

  localparam logic [23:0] BASE    = 24'h02_4000;
  localparam int          SAT_MAX = 32'h1_2000;

  logic        clk;
  logic        rst;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic [31:0] csr_tx_rdata;
  logic [31:0] csr_rx_rdata;
  logic        adc_en;
  logic        adc_vld;
  logic [15:0] adc_data;
  logic        dma_vld;
  logic        dma_rdy;
  logic [23:0] dma_addr;
  logic [15:0] dma_data;
  logic        oflow;

  int checkCount = 0;
  int passCount  = 0;

  logic [15:0] got_data [$];
  logic [23:0] got_addr [$];
  int          oflow_seen = 0;

  adc_capture_ctrl #(
    .CLK_MHZ    (50),
    .SDRAM_BASE (BASE),
    .TEST_DIV   (25),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .csr_we       (csr_we),
    .csr_wdata    (csr_wdata),
    .csr_tx_rdata (csr_tx_rdata),
    .csr_rx_rdata (csr_rx_rdata),
    .adc_en       (adc_en),
    .adc_vld      (adc_vld),
    .adc_data     (adc_data),
    .dma_vld      (dma_vld),
    .dma_rdy      (dma_rdy),
    .dma_addr     (dma_addr),
    .dma_data     (dma_data),
    .oflow        (oflow)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transfer and overflow monitor, sampled mid-cycle so values are settled.
  always @(negedge clk) begin
    if (dma_vld && dma_rdy) begin
      got_data.push_back(dma_data);
      got_addr.push_back(dma_addr);
    end
    if (oflow) oflow_seen++;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One-cycle CSR write of {busy=0, test, rsvd=0, time_us}; returns 1 ns after the sampling edge.
  task automatic applyStimulus(input logic test, input logic [14:0] time_us);
    csr_we    = 1'b1;
    csr_wdata = {1'b0, test, 15'b0, time_us};
    @(posedge clk); #1;
    csr_we    = 1'b0;
    csr_wdata = '0;
  endtask

  // Waits for busy to drop, bounded; returns the number of busy cycles seen.
  task automatic waitIdle(input int bound, output int cycles);
    cycles = 0;
    while (csr_tx_rdata[31] && cycles < bound) begin
      cycles++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n;
    int base_idx;
    int base_of;
    int en_cnt;
    logic [15:0] exp_q [$];

    rst = 1'b1; csr_we = 1'b0; csr_wdata = '0;
    adc_vld = 1'b0; adc_data = '0; dma_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_tx", csr_tx_rdata, 32'h0);
    checkOutput("rst_rx", csr_rx_rdata, 32'h0);
    checkOutput("rst_adc_en", {31'b0, adc_en}, 32'h0);
    checkOutput("rst_dma_vld", {31'b0, dma_vld}, 32'h0);
    checkOutput("rst_oflow", {31'b0, oflow}, 32'h0);
    checkOutput("rst_dma_addr", {8'b0, dma_addr}, {8'b0, BASE});
    rst = 1'b0;
    @(posedge clk); #1;

    // Test-pattern window: 10 us at 50 MHz, one sample every 25 clocks.
    $display("[TB] test-pattern window");
    dma_rdy  = 1'b1;
    base_idx = got_data.size();
    applyStimulus(1'b1, 15'd10);
    checkOutput("t1_busy", {31'b0, csr_tx_rdata[31]}, 32'h1);
    checkOutput("t1_adc_en_off", {31'b0, adc_en}, 32'h0);
    waitIdle(2000, n);
    checkOutput("t1_idle", {31'b0, csr_tx_rdata[31]}, 32'h0);
    checkOutput("t1_busy_len_ok", {31'b0, (n >= 501 && n <= 503)}, 32'h1);
    checkOutput("t1_xfers", got_data.size() - base_idx, 32'd20);
    for (int j = 0; j < 20 && base_idx + j < got_data.size(); j++) begin
      checkOutput($sformatf("t1_data%0d", j), {16'b0, got_data[base_idx+j]}, j);
      checkOutput($sformatf("t1_addr%0d", j), {8'b0, got_addr[base_idx+j]}, {8'b0, BASE + 24'(2*j)});
    end
    checkOutput("t1_sample_cnt", csr_rx_rdata, 32'd20);

    // Zero-length write only clears the sample count.
    $display("[TB] zero-length write");
    applyStimulus(1'b0, 15'd0);
    checkOutput("t3_busy", {31'b0, csr_tx_rdata[31]}, 32'h0);
    checkOutput("t3_sample_cnt", csr_rx_rdata, 32'h0);
    @(posedge clk); #1;
    checkOutput("t3_still_idle", {31'b0, csr_tx_rdata[31]}, 32'h0);

    // Real-mode 10 us window with a second write mid-run that must be ignored.
    $display("[TB] write while busy");
    applyStimulus(1'b0, 15'd10);
    checkOutput("t2_busy", {31'b0, csr_tx_rdata[31]}, 32'h1);
    checkOutput("t2_adc_en", {31'b0, adc_en}, 32'h1);
    en_cnt = 0;
    for (int i = 0; i < 800 && csr_tx_rdata[31]; i++) begin
      if (adc_en) en_cnt++;
      if (i == 100) begin
        csr_we    = 1'b1;
        csr_wdata = {1'b0, 1'b1, 15'b0, 15'd99};
      end else begin
        csr_we    = 1'b0;
        csr_wdata = '0;
      end
      @(posedge clk); #1;
    end
    checkOutput("t2_en_cycles", en_cnt, 32'd500);
    checkOutput("t2_idle", {31'b0, csr_tx_rdata[31]}, 32'h0);
    checkOutput("t2_sample_cnt", csr_rx_rdata, 32'h0);

    // Back-pressure: adc_vld every cycle, dma_rdy low for the first 10 RUN cycles.
    $display("[TB] back-pressure overflow");
    dma_rdy  = 1'b0;
    base_idx = got_data.size();
    base_of  = oflow_seen;
    applyStimulus(1'b0, 15'd1);
    adc_vld = 1'b1;
    for (int i = 2; i <= 60; i++) begin
      if (i == 12) begin
        checkOutput("t4_hold_vld", {31'b0, dma_vld}, 32'h1);
        checkOutput("t4_hold_data", {16'b0, dma_data}, 32'd2);
        checkOutput("t4_hold_addr", {8'b0, dma_addr}, {8'b0, BASE});
        dma_rdy = 1'b1;
      end
      adc_data = 16'(i);
      @(posedge clk); #1;
    end
    adc_vld = 1'b0;
    waitIdle(200, n);
    checkOutput("t4_idle", {31'b0, csr_tx_rdata[31]}, 32'h0);
    checkOutput("t4_oflow_pulses", oflow_seen - base_of, 32'd6);
    exp_q.delete();
    for (int v = 2; v <= 51; v++) begin
      if (v <= 5 || v >= 12) exp_q.push_back(16'(v));
    end
    checkOutput("t4_xfers", got_data.size() - base_idx, 32'd44);
    for (int j = 0; j < exp_q.size() && base_idx + j < got_data.size(); j++) begin
      checkOutput($sformatf("t4_data%0d", j), {16'b0, got_data[base_idx+j]}, {16'b0, exp_q[j]});
      checkOutput($sformatf("t4_addr%0d", j), {8'b0, got_addr[base_idx+j]}, {8'b0, BASE + 24'(2*j)});
    end
    checkOutput("t4_sample_cnt", csr_rx_rdata, 32'd44);

    // Reset in the middle of RUN with data in flight, then a clean restart.
    $display("[TB] reset mid-run");
    applyStimulus(1'b0, 15'd5);
    adc_vld = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    checkOutput("t6_pre_vld", {31'b0, dma_vld}, 32'h1);
    checkOutput("t6_pre_cnt_nz", {31'b0, (csr_rx_rdata != 0)}, 32'h1);
    rst     = 1'b1;
    dma_rdy = 1'b0;
    @(posedge clk); #1;
    checkOutput("t6_rst_vld", {31'b0, dma_vld}, 32'h0);
    checkOutput("t6_rst_busy", csr_tx_rdata, 32'h0);
    checkOutput("t6_rst_cnt", csr_rx_rdata, 32'h0);
    checkOutput("t6_rst_adc_en", {31'b0, adc_en}, 32'h0);
    checkOutput("t6_rst_addr", {8'b0, dma_addr}, {8'b0, BASE});
    rst     = 1'b0;
    adc_vld = 1'b0;
    dma_rdy = 1'b1;
    @(posedge clk); #1;
    checkOutput("t6_rst_oflow", {31'b0, oflow}, 32'h0);
    base_idx = got_data.size();
    applyStimulus(1'b1, 15'd2);
    waitIdle(400, n);
    checkOutput("t6_idle", {31'b0, csr_tx_rdata[31]}, 32'h0);
    checkOutput("t6_xfers", got_data.size() - base_idx, 32'd4);
    for (int j = 0; j < 4 && base_idx + j < got_data.size(); j++) begin
      checkOutput($sformatf("t6_data%0d", j), {16'b0, got_data[base_idx+j]}, j);
      checkOutput($sformatf("t6_addr%0d", j), {8'b0, got_addr[base_idx+j]}, {8'b0, BASE + 24'(2*j)});
    end
    checkOutput("t6_sample_cnt", csr_rx_rdata, 32'd4);

    // Saturation: 75000 RUN cycles of continuous samples, only 0x12000 kept.
    $display("[TB] sample-count saturation");
    base_idx = got_data.size();
    base_of  = oflow_seen;
    applyStimulus(1'b0, 15'd1500);
    adc_vld = 1'b1;
    waitIdle(80000, n);
    adc_vld = 1'b0;
    @(posedge clk); #1;
    checkOutput("t5_idle", {31'b0, csr_tx_rdata[31]}, 32'h0);
    checkOutput("t5_sample_cnt", csr_rx_rdata, SAT_MAX);
    checkOutput("t5_xfers", got_data.size() - base_idx, SAT_MAX);
    checkOutput("t5_oflow_pulses", oflow_seen - base_of, 32'd1272);
    if (got_addr.size() > 0) begin
      checkOutput("t5_last_addr", {8'b0, got_addr[got_addr.size()-1]}, {8'b0, BASE + 24'h02_3FFE});
    end
    checkOutput("t5_final_addr", {8'b0, dma_addr}, {8'b0, BASE + 24'h02_4000});

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
